// File: rtl/mux4_rr_select.sv
// Round-robin select generator for the 4:1 mux select input.
// It grants one requester at a time and releases on done, on a requester drop, or on the hold limit.
module mux4_rr_select #(
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned CW       = $clog2(MAX_HOLD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] S,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_S;
    logic [3:0]      r_grant;
    logic            r_valid;
    logic            r_timeout;
    logic [1:0]      r_ptr;
    logic [CW-1:0]   r_hold_cnt;

    logic [1:0]      w_S_nxt;
    logic [3:0]      w_grant_nxt;
    logic            w_valid_nxt;
    logic            w_timeout_nxt;
    logic [1:0]      w_ptr_nxt;
    logic [CW-1:0]   w_hold_nxt;

    logic [1:0]      w_srch_ptr;
    logic            w_found;
    logic [1:0]      w_win;
    logic            w_hold_last;
    logic            w_release;

    // A release searches from the new pointer within the same cycle, so the
    // channel just released ends up with the lowest priority.
    always_comb begin
        w_srch_ptr = (r_state == ST_GRANT) ? 2'(r_S + 2'd1) : r_ptr;
        w_found    = 1'b0;
        w_win      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            logic [1:0] w_idx;
            w_idx = 2'(w_srch_ptr + 2'(i));
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_hold_last = (r_hold_cnt == CW'(MAX_HOLD - 1));
        w_release   = done | ~req[r_S] | w_hold_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_S        <= '0;
            r_grant    <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_S        <= w_S_nxt;
            r_grant    <= w_grant_nxt;
            r_valid    <= w_valid_nxt;
            r_timeout  <= w_timeout_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release && !w_found) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_S_nxt       = r_S;
        w_grant_nxt   = r_grant;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_S_nxt     = w_win;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end else begin
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // A simultaneous done or owner drop makes this a normal release.
                    w_ptr_nxt     = 2'(r_S + 2'd1);
                    w_timeout_nxt = w_hold_last & ~done & req[r_S];
                    if (w_found) begin
                        w_S_nxt     = w_win;
                        w_grant_nxt = 4'b0001 << w_win;
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = '0;
                    end else begin
                        w_grant_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
                    w_hold_nxt = CW'(r_hold_cnt + 1'b1);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign S       = r_S;
    assign grant   = r_grant;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Directed bench for mux4_rr_select: a vector table for rotation and drops,
// plus hand sequences for the hold limit, the coincidence case and async reset.
module tb_mux4_rr_select;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] S;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int total;
    int bad;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [1:0] s;
        logic [3:0] grant;
        logic       valid;
        logic       timeout;
    } vec_t;

    vec_t tbl[15];

    mux4_rr_select #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .S       (S),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] s, input logic [3:0] g,
                             input logic v, input logic t);
        chk({tag, " S"}, 32'(S), 32'(s));
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " valid"}, 32'(valid), 32'(v));
        chk({tag, " timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //            req      done s   grant    v  t
        tbl[0]  = '{4'b1111, 1'b0, 0, 4'b0001, 1, 0};
        tbl[1]  = '{4'b1111, 1'b1, 1, 4'b0010, 1, 0};
        tbl[2]  = '{4'b1111, 1'b0, 1, 4'b0010, 1, 0};
        tbl[3]  = '{4'b1111, 1'b1, 2, 4'b0100, 1, 0};
        tbl[4]  = '{4'b1111, 1'b0, 2, 4'b0100, 1, 0};
        tbl[5]  = '{4'b1111, 1'b1, 3, 4'b1000, 1, 0};
        tbl[6]  = '{4'b1111, 1'b0, 3, 4'b1000, 1, 0};
        tbl[7]  = '{4'b1111, 1'b1, 0, 4'b0001, 1, 0};
        tbl[8]  = '{4'b1001, 1'b0, 0, 4'b0001, 1, 0};
        tbl[9]  = '{4'b1000, 1'b0, 3, 4'b1000, 1, 0};
        tbl[10] = '{4'b0000, 1'b0, 3, 4'b0000, 0, 0};
        tbl[11] = '{4'b0000, 1'b1, 3, 4'b0000, 0, 0};
        tbl[12] = '{4'b0100, 1'b0, 2, 4'b0100, 1, 0};
        tbl[13] = '{4'b0110, 1'b0, 2, 4'b0100, 1, 0};
        tbl[14] = '{4'b0110, 1'b1, 1, 4'b0010, 1, 0};

        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].req, tbl[i].done);
            check_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].grant, tbl[i].valid, tbl[i].timeout);
        end

        // First grant after reset, then asynchronous reset between edges.
        do_reset();
        step(4'b0100, 1'b0);
        check_out("first_grant", 2'd2, 4'b0100, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0101, 1'b0);
        check_out("post_rst", 2'd0, 4'b0001, 1'b1, 1'b0);

        // Single requester hits the hold limit and is re-granted to itself.
        do_reset();
        step(4'b0010, 1'b0);
        check_out("to_grant", 2'd1, 4'b0010, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step(4'b0010, 1'b0);
            check_out($sformatf("to_hold%0d", k), 2'd1, 4'b0010, 1'b1, 1'b0);
        end
        step(4'b0010, 1'b0);
        check_out("to_pulse", 2'd1, 4'b0010, 1'b1, 1'b1);
        step(4'b0010, 1'b0);
        check_out("to_pulse_end", 2'd1, 4'b0010, 1'b1, 1'b0);

        // Second requester arrives; the limit moves the grant 1 -> 0 via ptr wrap.
        for (int k = 0; k < 6; k++) begin
            step(4'b0011, 1'b0);
            check_out($sformatf("to2_hold%0d", k), 2'd1, 4'b0010, 1'b1, 1'b0);
        end
        step(4'b0011, 1'b0);
        check_out("to2_move", 2'd0, 4'b0001, 1'b1, 1'b1);

        // done coincides with the hold limit: normal release, no timeout.
        for (int k = 0; k < 7; k++) begin
            step(4'b0001, 1'b0);
            check_out($sformatf("co_hold%0d", k), 2'd0, 4'b0001, 1'b1, 1'b0);
        end
        step(4'b0001, 1'b1);
        check_out("co_release", 2'd0, 4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b0);
        check_out("co_after", 2'd0, 4'b0001, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_select.md
Name: mux4_rr_select

Overview:
- Round-robin select generator that drives the 2-bit select of the team's 4:1 mux (mux4to1 S input). It sits directly upstream of that mux.
- Four requesters assert req[n]; the block grants one channel at a time and holds the mux select on it.
- It releases the grant on done, on requester drop, or on a hold timeout, then rotates priority.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release; legal range 2..256.
- CW, $clog2(MAX_HOLD), width of the hold counter; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per channel, level-sensitive; bit n requests mux input I[n].
- done  input  1  current owner finished; sampled only while valid=1.
- S  output  2  registered mux select; connects to mux4to1 S.
- grant  output  4  registered one-hot grant; equals 1<<S when valid=1, else 0.
- valid  output  1  registered; 1 while a channel owns the mux.
- timeout  output  1  registered one-cycle pulse when a grant is forcibly released by the hold limit.

Behaviour:
- Reset (rst_n=0, asynchronous): S=0, grant=0, valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE. Reset asserted mid-grant clears everything immediately, with no waiting for clk.
- Priority search: starting at ptr, scan ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted req wins.
- State IDLE (valid=0):
  - If req != 0, the next edge loads S=winner, grant=1<<winner, valid=1, hold_cnt=0, state=GRANT.
  - Latency is 1 cycle from the sampled req to valid.
  - If req == 0, stay in IDLE. S holds its last value so the mux output is stable. grant=0.
- State GRANT (valid=1):
  - hold_cnt increments each cycle.
  - Release condition at an edge: done=1, OR req[S]=0, OR hold_cnt==MAX_HOLD-1.
  - On release: ptr = S+1 (mod 4), wrapping 3->0. The search uses the new ptr in the same cycle, so the released channel has the lowest priority.
  - If any req is pending after release, the next grant loads at the same edge: no bubble, valid stays 1, S/grant update, hold_cnt=0.
  - If no req is pending after release, go to IDLE with valid=0 and grant=0; S is unchanged.
- timeout pulses 1 for exactly one cycle after a release caused only by the hold limit.
  - If done=1 or req[S]=0 coincides with the limit, treat it as a normal release with timeout=0.
- A single requester that times out while still requesting is re-granted to itself at the same edge: S is unchanged, valid stays 1, hold_cnt restarts, and timeout pulses.
- done while valid=0 is ignored.
- req changes on non-owner channels never disturb the current grant.
- Invariants:
  - grant is always one-hot or zero.
  - grant != 0 exactly when valid=1.
  - hold_cnt never exceeds MAX_HOLD-1.

Test Plan:
- Reset/first grant: hold rst_n=0 → S=0, grant=0, valid=0, timeout=0. Release reset, apply req=4'b0100 → after 1 edge S=2, grant=4'b0100, valid=1.
- Rotation: req=4'b1111 held, done pulsed 1 cycle after each grant → S sequence 0,1,2,3,0 with valid continuously 1 and no idle bubble.
- Timeout: MAX_HOLD=8, req=4'b0010 held, done=0 → S=1 for 8 cycles, timeout=1 on the cycle after the 8th, S stays 1, valid stays 1. With req=4'b0011 instead → the grant moves 1→0 after the timeout (ptr=2 wraps to 0).
- Requester drop: req=4'b1001, ch0 granted; deassert req[0] → next edge S=3, grant=4'b1000. Then drop req[3] with req=0 → valid=0, grant=0, S stays 3.
- Coincidence: done=1 on the cycle hold_cnt=MAX_HOLD-1 → release with timeout=0.
- Async reset mid-grant: assert rst_n=0 between edges while S=2, valid=1 → outputs clear immediately. After release, req=4'b0101 → S=0 (ptr reset to 0).
